// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared types, CRC constants and CRC byte step for the configuration-chain loader
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One byte of CRC-16-CCITT, data processed MSB first within the byte.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// rtl/ccff_crc16.sv - CRC-16-CCITT accumulator over configuration slices
// Ports: clk, resetn (async active-low), init (reload CRC_INIT), enable (absorb data_in),
//        data_in [DATA_W-1:0] (slice, zero-extended to whole bytes, low byte first), crc_out [15:0].
module ccff_crc16
    import ccff_loader_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic [15:0]       crc_out
);

    localparam int NBYTES = (DATA_W + 7) / 8;

    logic [NBYTES*8-1:0] padded;
    logic [15:0]         crc_next;

    // All bytes of a slice are folded in within one cycle; slices arrive at most every 3 cycles.
    always_comb begin
        padded = '0;
        padded[DATA_W-1:0] = data_in;
        crc_next = crc_out;
        for (int b = 0; b < NBYTES; b++) begin
            crc_next = crc16_step(crc_next, padded[b*8 +: 8]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_out <= CRC_INIT;
        end else if (init) begin
            crc_out <= CRC_INIT;
        end else if (enable) begin
            crc_out <= crc_next;
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - sequences bitstream shifting into the fabric configuration chains
// Ports: clk, global_resetn (async active-low), start (load pulse), cfg_data/cfg_valid/cfg_ready (slice input),
//        ccff_head/prog_clock/fabric_resetn (fabric pins), busy/done/error/shift_count (status),
//        crc_expected [15:0] (only when CCFF_CRC_EN is defined; enables CRC check of the bitstream).
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int NUM_CHAINS = 10,
    parameter int CHAIN_LEN  = 16,
    parameter int RST_HOLD   = 4,
    parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  global_resetn,
    input  logic                  start,
    input  logic [NUM_CHAINS-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [NUM_CHAINS-1:0] ccff_head,
    output logic                  prog_clock,
    output logic                  fabric_resetn,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CNT_W-1:0]      shift_count
`ifdef CCFF_CRC_EN
    ,
    input  logic [15:0]           crc_expected
`endif
);

    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                start_ok;
    logic                accept;
    logic                last_shift;
    logic                crc_ok;

    assign cfg_ready  = (state == S_WAIT_DATA);
    assign accept     = cfg_ready && cfg_valid;
    assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    // In PULSE, the count about to be written reaches CHAIN_LEN.
    assign last_shift = (shift_count == CNT_W'(CHAIN_LEN - 1));

`ifdef CCFF_CRC_EN
    logic [15:0] crc_value;

    ccff_crc16 #(
        .DATA_W(NUM_CHAINS)
    ) u_crc (
        .clk    (clk),
        .resetn (global_resetn),
        .init   (start_ok),
        .enable (accept),
        .data_in(cfg_data),
        .crc_out(crc_value)
    );

    assign crc_ok = (crc_value == crc_expected);
`else
    assign crc_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state         <= S_IDLE;
            hold_cnt      <= '0;
            ccff_head     <= '0;
            prog_clock    <= 1'b0;
            fabric_resetn <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            shift_count   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_ok) begin
                        state         <= S_WAIT_DATA;
                        fabric_resetn <= 1'b0;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        shift_count   <= '0;
                        busy          <= 1'b1;
                        prog_clock    <= 1'b0;
                    end
                end
                S_WAIT_DATA: begin
                    if (accept) begin
                        ccff_head <= cfg_data;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Data has been stable for a full cycle before this rising edge.
                    prog_clock <= 1'b1;
                    state      <= S_PULSE;
                end
                S_PULSE: begin
                    prog_clock <= 1'b0;
                    if (shift_count != CNT_W'(CHAIN_LEN)) begin
                        shift_count <= shift_count + 1'b1;
                    end
                    if (last_shift) begin
                        if (crc_ok) begin
                            state    <= S_HOLD;
                            hold_cnt <= '0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state <= S_WAIT_DATA;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
                        fabric_resetn <= 1'b1;
                        done          <= 1'b1;
                        busy          <= 1'b0;
                        state         <= S_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - directed self-checking bench for ccff_loader
module tb_ccff_loader;

    logic       clk;
    logic       global_resetn;
    logic       start;
    logic [9:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [9:0] ccff_head;
    logic       prog_clock;
    logic       fabric_resetn;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] shift_count;
    logic [15:0] model_crc;
    logic [15:0] crc_corrupt;

    int vectors = 0;
    int errors  = 0;
    int pulse_cnt = 0;
    int gap_pulses = 0;
    int drop_cnt = 0;

`ifdef CCFF_CRC_EN
    logic [15:0] crc_expected;
    always_comb crc_expected = model_crc ^ crc_corrupt;
`endif

    ccff_loader #(
        .NUM_CHAINS(10),
        .CHAIN_LEN (16),
        .RST_HOLD  (4)
    ) dut (
        .clk          (clk),
        .global_resetn(global_resetn),
        .start        (start),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .prog_clock   (prog_clock),
        .fabric_resetn(fabric_resetn),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .shift_count  (shift_count)
`ifdef CCFF_CRC_EN
        ,
        .crc_expected (crc_expected)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge prog_clock) pulse_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Bit-serial CRC-16-CCITT; slice split into low byte then high byte, each MSB first.
    function automatic logic [15:0] crc_model(input logic [15:0] crc, input logic [9:0] d);
        logic [15:0] c;
        logic [15:0] bytes;
        logic fb;
        c = crc;
        bytes = {6'b0, d[9:8], d[7:0]};
        for (int b = 0; b < 2; b++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ bytes[b*8 + k];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic pulse_start();
        cfg_valid = 1'b0;
        start = 1'b1;
        model_crc = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one slice (after an optional valid-low gap) and records what the fabric pins do.
    task automatic feed_slice(input logic [9:0] d, input logic [9:0] nxt, input int gap,
                              output logic [9:0] head_setup, output logic pc_setup,
                              output logic [9:0] head_pulse, output logic pc_pulse,
                              output logic pc_after, output logic [4:0] cnt_after,
                              output bit accepted);
        accepted = 1'b0;
        head_setup = '0; pc_setup = 1'b0; head_pulse = '0; pc_pulse = 1'b0;
        pc_after = 1'b0; cnt_after = '0;
        if (gap > 0) begin
            cfg_valid = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                if (prog_clock) gap_pulses++;
            end
        end
        cfg_data = d;
        cfg_valid = 1'b1;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (cfg_ready) accepted = 1'b1;
            else @(negedge clk);
        end
        if (accepted) begin
            model_crc = crc_model(model_crc, d);
            @(negedge clk);
            head_setup = ccff_head;
            pc_setup = prog_clock;
            cfg_data = nxt;
            @(negedge clk);
            head_pulse = ccff_head;
            pc_pulse = prog_clock;
            @(negedge clk);
            pc_after = prog_clock;
            cnt_after = shift_count;
        end
    endtask

    task automatic load_slices(input int first, input int last, input logic [9:0] xorv, input int gap);
        logic [9:0] hs, hp;
        logic ps, pp, pa;
        logic [4:0] ca;
        bit acc;
        for (int i = first; i <= last; i++) begin
            feed_slice(10'(i + 1) ^ xorv, 10'(i + 2) ^ xorv, gap, hs, ps, hp, pp, pa, ca, acc);
            if (!acc) drop_cnt++;
        end
    endtask

    task automatic wait_release(output int cycles);
        cycles = 0;
        while (fabric_resetn !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        global_resetn = 1'b0;
        start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        crc_corrupt = '0;
        model_crc = 16'hFFFF;
        @(negedge clk);
        vectors++; if ({ccff_head, prog_clock, fabric_resetn, cfg_ready} !== 13'h0) begin errors++; $display("FAIL reset_pins: got %h want 0", {ccff_head, prog_clock, fabric_resetn, cfg_ready}); end
        vectors++; if ({busy, done, error} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {busy, done, error}); end
        vectors++; if (shift_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", shift_count); end
        global_resetn = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 10'h155;
        repeat (2) @(negedge clk);
        vectors++; if ({busy, ccff_head} !== 11'h0) begin errors++; $display("FAIL idle_ignores_valid: got %h want 0", {busy, ccff_head}); end
        cfg_valid = 1'b0;
    endtask

    task automatic test_basic();
        logic [9:0] hs, hp;
        logic ps, pp, pa;
        logic [4:0] ca;
        bit acc;
        int base, cyc;
        base = pulse_cnt;
        pulse_start();
        vectors++; if ({busy, cfg_ready, fabric_resetn} !== 3'b110) begin errors++; $display("FAIL basic_started: got %b want 110", {busy, cfg_ready, fabric_resetn}); end
        for (int i = 0; i < 16; i++) begin
            feed_slice(10'(i + 1), 10'(i + 2), 0, hs, ps, hp, pp, pa, ca, acc);
            vectors++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept[%0d]: got %b want 1", i, acc); end
            vectors++; if ({hs, ps} !== {10'(i + 1), 1'b0}) begin errors++; $display("FAIL basic_setup[%0d]: got head %h clk %b want head %h clk 0", i, hs, ps, 10'(i + 1)); end
            vectors++; if ({hp, pp} !== {10'(i + 1), 1'b1}) begin errors++; $display("FAIL basic_pulse[%0d]: got head %h clk %b want head %h clk 1", i, hp, pp, 10'(i + 1)); end
            vectors++; if ({pa, ca} !== {1'b0, 5'(i + 1)}) begin errors++; $display("FAIL basic_after[%0d]: got clk %b count %0d want clk 0 count %0d", i, pa, ca, i + 1); end
        end
        vectors++; if ({fabric_resetn, done, busy} !== 3'b001) begin errors++; $display("FAIL basic_hold: got %b want 001", {fabric_resetn, done, busy}); end
        wait_release(cyc);
        vectors++; if (cyc !== 4) begin errors++; $display("FAIL basic_release_delay: got %0d want 4", cyc); end
        vectors++; if ({done, busy, error, prog_clock} !== 4'b1000) begin errors++; $display("FAIL basic_done: got %b want 1000", {done, busy, error, prog_clock}); end
        vectors++; if (shift_count !== 5'd16) begin errors++; $display("FAIL basic_count: got %0d want 16", shift_count); end
        vectors++; if (ccff_head !== 10'h010) begin errors++; $display("FAIL basic_last_head: got %h want 010", ccff_head); end
        vectors++; if (pulse_cnt - base !== 16) begin errors++; $display("FAIL basic_pulses: got %0d want 16", pulse_cnt - base); end
    endtask

    task automatic test_gaps();
        int base, cyc;
        base = pulse_cnt;
        gap_pulses = 0;
        drop_cnt = 0;
        pulse_start();
        load_slices(0, 15, 10'h000, 5);
        vectors++; if (gap_pulses !== 0) begin errors++; $display("FAIL gaps_clock_idle: got %0d want 0", gap_pulses); end
        wait_release(cyc);
        vectors++; if ({drop_cnt, cyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL gaps_release: got drops %0d delay %0d want 0 4", drop_cnt, cyc); end
        vectors++; if ({done, shift_count, ccff_head} !== {1'b1, 5'd16, 10'h010}) begin errors++; $display("FAIL gaps_final: got %b/%0d/%h want 1/16/010", done, shift_count, ccff_head); end
        vectors++; if (pulse_cnt - base !== 16) begin errors++; $display("FAIL gaps_pulses: got %0d want 16", pulse_cnt - base); end
    endtask

    task automatic test_start_ignored();
        int base, cyc;
        base = pulse_cnt;
        drop_cnt = 0;
        pulse_start();
        load_slices(0, 6, 10'h2A5, 0);
        cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++; if ({busy, fabric_resetn, cfg_ready, shift_count} !== {3'b101, 5'd7}) begin errors++; $display("FAIL midstart_ignored: got %b count %0d want 101 count 7", {busy, fabric_resetn, cfg_ready}, shift_count); end
        load_slices(7, 15, 10'h2A5, 0);
        wait_release(cyc);
        vectors++; if ({drop_cnt, cyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL midstart_release: got drops %0d delay %0d want 0 4", drop_cnt, cyc); end
        vectors++; if ({done, shift_count, ccff_head} !== {1'b1, 5'd16, 10'h2B5}) begin errors++; $display("FAIL midstart_final: got %b/%0d/%h want 1/16/2b5", done, shift_count, ccff_head); end
        vectors++; if (pulse_cnt - base !== 16) begin errors++; $display("FAIL midstart_pulses: got %0d want 16", pulse_cnt - base); end
    endtask

    task automatic test_reset_midload();
        int base, cyc;
        drop_cnt = 0;
        pulse_start();
        load_slices(0, 8, 10'h0F0, 0);
        vectors++; if (shift_count !== 5'd9) begin errors++; $display("FAIL midreset_pre_count: got %0d want 9", shift_count); end
        #2;
        global_resetn = 1'b0;
        #1;
        vectors++; if ({ccff_head, prog_clock, fabric_resetn, cfg_ready, busy, done, error, shift_count} !== 21'h0) begin errors++; $display("FAIL midreset_async: got %h want 0", {ccff_head, prog_clock, fabric_resetn, cfg_ready, busy, done, error, shift_count}); end
        @(negedge clk);
        global_resetn = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        base = pulse_cnt;
        pulse_start();
        vectors++; if ({busy, shift_count} !== {1'b1, 5'd0}) begin errors++; $display("FAIL midreset_restart: got busy %b count %0d want 1 0", busy, shift_count); end
        load_slices(0, 15, 10'h0F0, 0);
        wait_release(cyc);
        vectors++; if ({drop_cnt, cyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL midreset_release: got drops %0d delay %0d want 0 4", drop_cnt, cyc); end
        vectors++; if ({done, shift_count, ccff_head} !== {1'b1, 5'd16, 10'h0E0}) begin errors++; $display("FAIL midreset_final: got %b/%0d/%h want 1/16/0e0", done, shift_count, ccff_head); end
        vectors++; if (pulse_cnt - base !== 16) begin errors++; $display("FAIL midreset_pulses: got %0d want 16", pulse_cnt - base); end
    endtask

    task automatic test_reload_from_done();
        int base, cyc;
        vectors++; if ({done, fabric_resetn} !== 2'b11) begin errors++; $display("FAIL reload_pre: got %b want 11", {done, fabric_resetn}); end
        base = pulse_cnt;
        drop_cnt = 0;
        pulse_start();
        vectors++; if ({fabric_resetn, done, busy, shift_count} !== {3'b001, 5'd0}) begin errors++; $display("FAIL reload_start: got %b count %0d want 001 count 0", {fabric_resetn, done, busy}, shift_count); end
        load_slices(0, 15, 10'h3FF, 0);
        wait_release(cyc);
        vectors++; if ({drop_cnt, cyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL reload_release: got drops %0d delay %0d want 0 4", drop_cnt, cyc); end
        vectors++; if ({done, shift_count, ccff_head} !== {1'b1, 5'd16, 10'h3EF}) begin errors++; $display("FAIL reload_final: got %b/%0d/%h want 1/16/3ef", done, shift_count, ccff_head); end
        vectors++; if (pulse_cnt - base !== 16) begin errors++; $display("FAIL reload_pulses: got %0d want 16", pulse_cnt - base); end
    endtask

`ifdef CCFF_CRC_EN
    task automatic test_crc();
        int cyc;
        drop_cnt = 0;
        crc_corrupt = 16'h0001;
        pulse_start();
        load_slices(0, 15, 10'h000, 0);
        repeat (6) @(negedge clk);
        vectors++; if ({error, fabric_resetn, done, busy} !== 4'b1000) begin errors++; $display("FAIL crc_bad: got %b want 1000", {error, fabric_resetn, done, busy}); end
        crc_corrupt = 16'h0000;
        pulse_start();
        vectors++; if ({error, busy} !== 2'b01) begin errors++; $display("FAIL crc_restart: got %b want 01", {error, busy}); end
        load_slices(0, 15, 10'h000, 0);
        wait_release(cyc);
        vectors++; if ({drop_cnt, cyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL crc_good_release: got drops %0d delay %0d want 0 4", drop_cnt, cyc); end
        vectors++; if ({done, error} !== 2'b10) begin errors++; $display("FAIL crc_good: got %b want 10", {done, error}); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_start_ignored();
        test_reset_midload();
        test_reload_from_done();
`ifdef CCFF_CRC_EN
        test_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
Name: ccff_loader

Overview:
Configuration-chain loader that sequences bitstream programming of fpga_top. Accepts a stream of chain slices, one bit per configuration chain per shift. Drives ccff_head and a generated prog_clock, counts CHAIN_LEN shifts, then holds the fabric in reset for RST_HOLD cycles before releasing it. Sits between the bitstream source (DMA/host FIFO) and the fabric's ccff_head/prog_clock/global_resetn pins.

Parameters:
NUM_CHAINS, 10, number of parallel configuration chains (width of ccff_head).
CHAIN_LEN, 16, shifts per chain (flip-flops per chain); must be >= 1.
RST_HOLD, 4, clk cycles fabric_resetn stays low after the last shift; must be >= 1.
CNT_W, $clog2(CHAIN_LEN+1), shift counter width (derived; do not override).

Ports:
clk  input  1  system clock; all state on rising edge.
global_resetn  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
cfg_data  input  NUM_CHAINS  chain slice; bit i goes to chain i.
cfg_valid  input  1  cfg_data valid.
cfg_ready  output  1  loader accepts a slice this cycle.
ccff_head  output  NUM_CHAINS  registered serial data to the fabric chains.
prog_clock  output  1  registered programming clock to the fabric.
fabric_resetn  output  1  registered active-low reset to the fabric.
busy  output  1  load in progress (any state except IDLE/DONE/ERROR).
done  output  1  load complete and fabric released; held until the next start.
error  output  1  load failed; fabric held in reset (CRC feature only).
shift_count  output  CNT_W  slices shifted so far in the current load.
crc_expected  input  16  expected CRC (present only with CCFF_CRC_EN).

Behaviour:
- Async reset: state=IDLE. ccff_head=0, prog_clock=0, fabric_resetn=0, cfg_ready=0, busy=0, done=0, error=0, shift_count=0.
- FSM states: IDLE, WAIT_DATA, SETUP, PULSE, HOLD, DONE, ERROR.
- IDLE/DONE/ERROR + start: next edge → WAIT_DATA. Same edge sets fabric_resetn=0, clears done/error and shift_count, busy=1. start in any other state is ignored.
- WAIT_DATA: cfg_ready=1 (combinational from state). On cfg_valid&&cfg_ready: capture cfg_data into ccff_head, → SETUP. No valid: stay; prog_clock stays 0 and ccff_head holds.
- SETUP: prog_clock=0, ccff_head stable. Next edge: prog_clock←1, → PULSE. Guarantees one full clk cycle of data setup before the prog_clock rising edge.
- PULSE: prog_clock=1 for exactly one cycle. Next edge: prog_clock←0 and shift_count increments.
  - New count < CHAIN_LEN: → WAIT_DATA.
  - New count == CHAIN_LEN: → HOLD (CRC variant: check first, see Optional Feature).
- Throughput: at most one slice per 3 clk cycles. Exactly CHAIN_LEN prog_clock pulses per load.
- HOLD: fabric_resetn=0, counts RST_HOLD cycles. Then fabric_resetn←1, done←1, busy←0, → DONE.
- DONE: fabric_resetn=1, ccff_head holds the last slice, prog_clock=0.
- ERROR: fabric_resetn=0, error=1, busy=0.
- cfg_ready=0 in every state except WAIT_DATA. cfg_valid outside WAIT_DATA is ignored (no capture).
- Reset mid-load: immediate return to reset values. Chains hold partial data; the next load must start again from slice 0.
- shift_count saturates at CHAIN_LEN and never wraps.

Optional Feature:
Macro CCFF_CRC_EN.
- Enabled:
  - Each accepted slice, zero-extended to a multiple of 8 bits LSB-first, updates a CRC-16-CCITT (poly 0x1021, init 0xFFFF).
  - In PULSE on the final shift, compare CRC with crc_expected. Match → HOLD. Mismatch → ERROR (fabric_resetn stays 0).
  - CRC is reinitialised on start.
- Disabled: crc_expected port absent, error is tied to 0, ERROR is unreachable.

Decomposition:
- Package ccff_loader_pkg: state enum, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF, function crc16_step(crc, byte).
- One sub-module, ccff_crc16 (instantiated only under CCFF_CRC_EN): init/enable/data_in inputs, crc_out output.

Test Plan:
- CHAIN_LEN=16, start, 16 slices 10'h001..10'h010 with cfg_valid always high → 16 prog_clock pulses, each preceded by one SETUP cycle with matching ccff_head. fabric_resetn rises exactly 4 cycles after the last pulse; done=1, shift_count=16.
- Insert 5-cycle cfg_valid gaps → prog_clock stays 0 during gaps, no extra pulses, same final state as the previous test.
- start pulsed at shift 7 → ignored; load completes normally with 16 pulses.
- global_resetn low at shift 9 → all outputs return to reset values immediately. A following start reloads from shift_count=0.
- From DONE, start → fabric_resetn←0 on the next edge, done←0, full reload succeeds.
- CCFF_CRC_EN, crc_expected deliberately wrong → after the 16th pulse error=1, fabric_resetn=0, done=0. With the correct CRC → done=1.
